// File: rtl/scrolling_text_engine_if.sv
// rtl/scrolling_text_engine_if.sv - text/control inputs and display outputs of the scrolling text engine
// master drives text and control; slave (the engine) drives the display.
interface scrolling_text_engine_if #(
   parameter int BUF_CHARS = 16,
   parameter int NUM_AN    = 4
);
   localparam int PW = (BUF_CHARS > 1) ? $clog2(BUF_CHARS) : 1;

   logic [BUF_CHARS*8-1:0] text_in;
   logic                   load;
   logic [1:0]             mode;
   logic                   freeze;
   logic [0:6]             seg;
   logic [NUM_AN-1:0]      an;
   logic [PW-1:0]          pos;
   logic                   wrapped;

   modport master (output text_in, load, mode, freeze,
                   input  seg, an, pos, wrapped);
   modport slave  (input  text_in, load, mode, freeze,
                   output seg, an, pos, wrapped);
endinterface

// File: rtl/scrolling_text_engine.sv
// rtl/scrolling_text_engine.sv - scrolls a text buffer across multiplexed 7-segment digits
// Modes: wrap-left, wrap-right, bounce, hold; seg and an are registered together.
module scrolling_text_engine #(
   parameter int BUF_CHARS      = 16,
   parameter int NUM_AN         = 4,
   parameter int SCROLL_CYCLES  = 25_000_000,
   parameter int REFRESH_CYCLES = 100_000,
   parameter int CW             = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   scrolling_text_engine_if.slave  bus
);
   localparam int PW   = (BUF_CHARS > 1) ? $clog2(BUF_CHARS) : 1;
   localparam int DW   = (NUM_AN > 1) ? $clog2(NUM_AN) : 1;
   localparam int MAXP = BUF_CHARS - NUM_AN;

   generate
      if (!(BUF_CHARS >= NUM_AN && NUM_AN >= 1)) begin : gBadParams
         $error("scrolling_text_engine: need BUF_CHARS >= NUM_AN >= 1");
      end
   endgenerate

   typedef enum logic {DIR_FWD, DIR_BWD} dir_t;

   logic [7:0]    textBuf [BUF_CHARS];
   logic [PW-1:0] pos, posNext;
   dir_t          dir, dirNext;
   logic          wrapped, wrapNext;
   logic [CW-1:0] scrollCnt;
   logic [CW-1:0] refCnt;
   logic [DW-1:0] digit;
   logic [0:6]    seg;
   logic [NUM_AN-1:0] an, anNext;
   logic [PW:0]   idxSum;
   logic [PW-1:0] charIdx;
   logic          scrollEn, tick;

   // Bounce with no room to move is treated exactly like hold.
   assign scrollEn = !bus.freeze && (bus.mode != 2'b11) && !((bus.mode == 2'b10) && (MAXP == 0));
   assign tick     = scrollEn && (scrollCnt == CW'(SCROLL_CYCLES - 1));

   always_comb begin
      posNext  = pos;
      dirNext  = dir;
      wrapNext = 1'b0;
      if (tick) begin
         case (bus.mode)
            2'b00: begin
               if (pos == PW'(BUF_CHARS - 1)) begin
                  posNext  = '0;
                  wrapNext = 1'b1;
               end else begin
                  posNext = pos + 1'b1;
               end
            end
            2'b01: begin
               if (pos == '0) begin
                  posNext  = PW'(BUF_CHARS - 1);
                  wrapNext = 1'b1;
               end else begin
                  posNext = pos - 1'b1;
               end
            end
            2'b10: begin
               if (pos > PW'(MAXP)) begin
                  posNext = PW'(MAXP);
                  dirNext = DIR_BWD;
               end else if (dir == DIR_FWD) begin
                  // Entering bounce while parked on the far edge just turns around.
                  if (pos == PW'(MAXP)) begin
                     posNext = PW'(MAXP - 1);
                     dirNext = DIR_BWD;
                  end else begin
                     posNext = pos + 1'b1;
                     if (posNext == PW'(MAXP)) begin
                        dirNext  = DIR_BWD;
                        wrapNext = 1'b1;
                     end
                  end
               end else begin
                  if (pos == '0) begin
                     posNext = PW'(1);
                     dirNext = DIR_FWD;
                  end else begin
                     posNext = pos - 1'b1;
                     if (posNext == '0) begin
                        dirNext  = DIR_FWD;
                        wrapNext = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BUF_CHARS; i++) textBuf[i] <= 8'h20;
         pos       <= '0;
         dir       <= DIR_FWD;
         scrollCnt <= '0;
         wrapped   <= 1'b0;
      end else if (bus.load) begin
         for (int i = 0; i < BUF_CHARS; i++) textBuf[i] <= bus.text_in[(BUF_CHARS-i)*8-1 -: 8];
         pos       <= '0;
         dir       <= DIR_FWD;
         scrollCnt <= '0;
         wrapped   <= 1'b0;
      end else begin
         pos     <= posNext;
         dir     <= dirNext;
         wrapped <= wrapNext;
         if (scrollEn) scrollCnt <= tick ? '0 : scrollCnt + 1'b1;
      end
   end

   function automatic logic [0:6] decode(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      case (u)
         "0": decode = 7'b0000001;  "1": decode = 7'b1001111;
         "2": decode = 7'b0010010;  "3": decode = 7'b0000110;
         "4": decode = 7'b1001100;  "5": decode = 7'b0100100;
         "6": decode = 7'b0100000;  "7": decode = 7'b0001111;
         "8": decode = 7'b0000000;  "9": decode = 7'b0000100;
         "A": decode = 7'b0001000;  "B": decode = 7'b1100000;
         "C": decode = 7'b0110001;  "D": decode = 7'b1000010;
         "E": decode = 7'b0110000;  "F": decode = 7'b0111000;
         "G": decode = 7'b0100001;  "H": decode = 7'b1001000;
         "I": decode = 7'b1111001;  "J": decode = 7'b1000011;
         "K": decode = 7'b0101000;  "L": decode = 7'b1110001;
         "M": decode = 7'b0101011;  "N": decode = 7'b1101010;
         "O": decode = 7'b1100010;  "P": decode = 7'b0011000;
         "Q": decode = 7'b0001100;  "R": decode = 7'b1111010;
         "S": decode = 7'b0100100;  "T": decode = 7'b1110000;
         "U": decode = 7'b1000001;  "V": decode = 7'b1100011;
         "W": decode = 7'b1010100;  "X": decode = 7'b1001001;
         "Y": decode = 7'b1000100;  "Z": decode = 7'b0010011;
         "-": decode = 7'b1111110;
         " ", 8'h00: decode = 7'b1111111;
         default: decode = 7'b1110111;
      endcase
   endfunction

   always_comb begin
      idxSum  = {1'b0, pos} + (PW+1)'(digit);
      charIdx = (idxSum >= (PW+1)'(BUF_CHARS)) ? PW'(idxSum - (PW+1)'(BUF_CHARS)) : PW'(idxSum);
      anNext  = '1;
      for (int k = 0; k < NUM_AN; k++) begin
         if (digit == DW'(k)) anNext[NUM_AN-1-k] = 1'b0;
      end
   end

   // seg and an both register the current digit select, so they stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         refCnt <= '0;
         digit  <= '0;
         seg    <= 7'b1111111;
         an     <= '1;
      end else begin
         if (refCnt == CW'(REFRESH_CYCLES - 1)) begin
            refCnt <= '0;
            digit  <= (digit == DW'(NUM_AN - 1)) ? '0 : digit + 1'b1;
         end else begin
            refCnt <= refCnt + 1'b1;
         end
         seg <= decode(textBuf[charIdx]);
         an  <= anNext;
      end
   end

   assign bus.seg     = seg;
   assign bus.an      = an;
   assign bus.pos     = pos;
   assign bus.wrapped = wrapped;
endmodule

// File: tb/tb_scrolling_text_engine.sv
// tb/tb_scrolling_text_engine.sv - scoreboard bench for scrolling_text_engine
// Driver steps a reference model per edge and queues expectations; monitor checks on negedge.
module tb_scrolling_text_engine;
   localparam int N    = 6;
   localparam int NA   = 4;
   localparam int SC   = 8;
   localparam int RC   = 2;
   localparam int MAXP = N - NA;

   typedef struct {
      int         pos;
      bit         wr;
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   logic clk;
   logic reset;
   scrolling_text_engine_if #(.BUF_CHARS(N), .NUM_AN(NA)) bus ();

   scrolling_text_engine #(
      .BUF_CHARS(N), .NUM_AN(NA), .SCROLL_CYCLES(SC), .REFRESH_CYCLES(RC), .CW(32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   nChecks = 0;
   int   nFail   = 0;
   exp_t expQ[$];

   byte unsigned mbuf [N];
   int  mpos, mdir, mcnt, mcyc;

   logic [6:0] digitGlyph  [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   logic [6:0] letterGlyph [26] = '{7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
                                    7'b0111000, 7'b0100001, 7'b1001000, 7'b1111001, 7'b1000011,
                                    7'b0101000, 7'b1110001, 7'b0101011, 7'b1101010, 7'b1100010,
                                    7'b0011000, 7'b0001100, 7'b1111010, 7'b0100100, 7'b1110000,
                                    7'b1000001, 7'b1100011, 7'b1010100, 7'b1001001, 7'b1000100,
                                    7'b0010011};

   function automatic logic [6:0] glyph(input byte unsigned c);
      if (c >= 48 && c <= 57)       return digitGlyph[c - 48];
      else if (c >= 65 && c <= 90)  return letterGlyph[c - 65];
      else if (c >= 97 && c <= 122) return letterGlyph[c - 97];
      else if (c == 45)             return 7'b1111110;
      else if (c == 32 || c == 0)   return 7'b1111111;
      else                          return 7'b1110111;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      nChecks++;
      if (act != req) begin
         nFail++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
      end
   endtask

   task automatic boundFail(input string name);
      nChecks++;
      nFail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // One clock edge: apply the behavioural rules to the inputs held across this edge.
   task automatic cyc();
      exp_t e;
      int   dig, np;
      bit   active;
      @(posedge clk);
      e.wr = 1'b0;
      if (reset) begin
         foreach (mbuf[i]) mbuf[i] = 8'h20;
         mpos = 0; mdir = 1; mcnt = 0; mcyc = 0;
         e.seg = 7'b1111111;
         e.an  = 4'b1111;
      end else begin
         dig   = (mcyc / RC) % NA;
         e.seg = glyph(mbuf[(mpos + dig) % N]);
         e.an  = ~(4'b0001 << (NA - 1 - dig));
         mcyc++;
         active = !bus.freeze && bus.mode != 2'd3 && !(bus.mode == 2'd2 && MAXP == 0);
         if (bus.load) begin
            for (int i = 0; i < N; i++) mbuf[i] = bus.text_in[(N-i)*8-1 -: 8];
            mpos = 0; mdir = 1; mcnt = 0;
         end else if (active) begin
            if (mcnt == SC - 1) begin
               mcnt = 0;
               case (bus.mode)
                  2'd0: begin np = (mpos + 1) % N; e.wr = (np == 0); mpos = np; end
                  2'd1: begin e.wr = (mpos == 0); mpos = (mpos + N - 1) % N; end
                  default: begin
                     if (mpos > MAXP) begin
                        mpos = MAXP; mdir = -1;
                     end else begin
                        np = mpos + mdir;
                        if (np > MAXP) begin
                           np = MAXP - 1; mdir = -1;
                        end else if (np < 0) begin
                           np = 1; mdir = 1;
                        end else if (np == MAXP || np == 0) begin
                           mdir = (np == MAXP) ? -1 : 1;
                           e.wr = 1'b1;
                        end
                        mpos = np;
                     end
                  end
               endcase
            end else begin
               mcnt++;
            end
         end
      end
      e.pos = mpos;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [6:0] s;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         s = bus.seg;
         chk("pos",     int'(bus.pos),     e.pos);
         chk("wrapped", int'(bus.wrapped), int'(e.wr));
         chk("an",      int'(bus.an),      int'(e.an));
         chk("seg",     int'(s),           int'(e.seg));
      end
   end

   task automatic loadText(input logic [N*8-1:0] t);
      bus.text_in = t;
      bus.load    = 1'b1;
      cyc();
      bus.load    = 1'b0;
   endtask

   initial begin
      int guard;
      logic [N*8-1:0] t;
      bus.text_in = '0;
      bus.load    = 1'b0;
      bus.mode    = 2'd0;
      bus.freeze  = 1'b0;
      reset       = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;

      // Wrap-left through a full revolution.
      t = "HELLO-";
      loadText(t);
      repeat (60) cyc();

      // Bounce, then freeze while bouncing.
      bus.mode = 2'd2;
      loadText(t);
      repeat (60) cyc();
      bus.freeze = 1'b1;
      repeat (40) cyc();
      bus.freeze = 1'b0;
      repeat (10) cyc();

      // Load coinciding with a tick at pos 3.
      bus.mode = 2'd0;
      loadText(t);
      guard = 0;
      while (!(mpos == 3 && mcnt == SC - 1) && guard < 200) begin cyc(); guard++; end
      if (guard >= 200) boundFail("wait_pos3_tick");
      loadText(t);
      repeat (10) cyc();

      // Decoder corner glyphs in hold mode.
      bus.mode = 2'd3;
      t = "0 -#Hz";
      loadText(t);
      repeat (20) cyc();

      // Wrap-right a little, then reset while at pos 4.
      bus.mode = 2'd1;
      t = "HELLO-";
      loadText(t);
      guard = 0;
      while (!(mpos == 4 && mcnt == 3) && guard < 200) begin cyc(); guard++; end
      if (guard >= 200) boundFail("wait_pos4");
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (10) cyc();

      // Random mix of modes, freezes, loads and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) bus.freeze = ~bus.freeze;
         if ($urandom_range(0, 49) == 0) begin
            for (int j = 0; j < N; j++) bus.text_in[j*8 +: 8] = 8'($urandom_range(0, 255));
            bus.load = 1'b1;
         end
         reset = ($urandom_range(0, 499) == 0);
         cyc();
         bus.load = 1'b0;
         reset    = 1'b0;
      end

      guard = 0;
      while (expQ.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
      if (expQ.size() > 0) boundFail("drain");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
